// File: rtl/calc1_pkg.sv
// Shared codes, widths and types for the four-port calculator.
// Pulled in by the ALU and the top level.
package calc1_pkg;

  localparam int DATA_W    = 32;
  localparam int CMD_W     = 4;
  localparam int RESP_W    = 2;
  localparam int NUM_PORTS = 4;

  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

  localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
  localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
  localparam logic [RESP_W-1:0] RESP_OVF  = 2'd2;
  localparam logic [RESP_W-1:0] RESP_INV  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GET_OP2 = 2'd1,
    ST_PENDING = 2'd2
  } port_state_e;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } req_t;

endpackage

// File: rtl/calc1_alu.sv
// Shared calculator datapath: add/sub with range check, logical shifts.
// Latency: purely combinational. Backpressure: none; result is zero unless resp is OK.
module calc1_alu
  import calc1_pkg::*;
(
  input  logic [CMD_W-1:0]  cmd,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] result,
  output logic [RESP_W-1:0] resp
);

  logic [DATA_W:0] sum;

  assign sum = {1'b0, op1} + {1'b0, op2};

  always_comb begin
    result = '0;
    resp   = RESP_INV;
    case (cmd)
      CMD_ADD: begin
        if (sum[DATA_W]) begin
          resp = RESP_OVF;
        end else begin
          resp   = RESP_OK;
          result = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (op2 > op1) begin
          resp = RESP_OVF;
        end else begin
          resp   = RESP_OK;
          result = op1 - op2;
        end
      end
      // Only the low five bits of op2 form the shift amount.
      CMD_SHL: begin
        resp   = RESP_OK;
        result = op1 << op2[4:0];
      end
      CMD_SHR: begin
        resp   = RESP_OK;
        result = op1 >> op2[4:0];
      end
      default: begin
        resp   = RESP_INV;
        result = '0;
      end
    endcase
  end

endmodule

// File: rtl/calc1_top.sv
// Four-port calculator: per-port op capture, fixed-priority grant onto one shared ALU.
// Latency: response visible 3 cycles after cmd. Backpressure: a busy port ignores new cmds until its response.
module calc1_top
  import calc1_pkg::*;
(
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  output logic [0:1]  out_resp1,
  output logic [0:31] out_data1,
  output logic [0:1]  out_resp2,
  output logic [0:31] out_data2,
  output logic [0:1]  out_resp3,
  output logic [0:31] out_data3,
  output logic [0:1]  out_resp4,
  output logic [0:31] out_data4
);

  logic [CMD_W-1:0]  cmd_in  [NUM_PORTS];
  logic [DATA_W-1:0] data_in [NUM_PORTS];

  port_state_e       state_q [NUM_PORTS];
  port_state_e       state_d [NUM_PORTS];
  req_t              req_q   [NUM_PORTS];
  req_t              req_d   [NUM_PORTS];

  logic [RESP_W-1:0] resp_q  [NUM_PORTS];
  logic [DATA_W-1:0] data_q  [NUM_PORTS];

  logic [NUM_PORTS-1:0] grant;
  logic [1:0]           gnt_idx;
  logic                 gnt_vld;
  logic [DATA_W-1:0]    alu_result;
  logic [RESP_W-1:0]    alu_resp;

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  // Lowest-numbered pending port wins; scanning downwards leaves it last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (state_q[i] == ST_PENDING) begin
        gnt_vld = 1'b1;
        gnt_idx = 2'(i);
      end
    end
    if (gnt_vld) grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      state_d[i] = state_q[i];
      req_d[i]   = req_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (cmd_in[i] != '0) begin
            state_d[i]   = ST_GET_OP2;
            req_d[i].cmd = cmd_in[i];
            req_d[i].op1 = data_in[i];
          end
        end
        ST_GET_OP2: begin
          state_d[i]   = ST_PENDING;
          req_d[i].op2 = data_in[i];
        end
        ST_PENDING: begin
          if (grant[i]) state_d[i] = ST_IDLE;
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i] <= ST_IDLE;
        req_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i] <= state_d[i];
        req_q[i]   <= req_d[i];
      end
    end
  end

  calc1_alu u_alu (
    .cmd    (req_q[gnt_idx].cmd),
    .op1    (req_q[gnt_idx].op1),
    .op2    (req_q[gnt_idx].op2),
    .result (alu_result),
    .resp   (alu_resp)
  );

  // Non-granted ports are rewritten with zero every cycle, giving one-cycle responses.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        resp_q[i] <= RESP_NONE;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        resp_q[i] <= grant[i] ? alu_resp   : RESP_NONE;
        data_q[i] <= grant[i] ? alu_result : '0;
      end
    end
  end

  assign out_resp1 = resp_q[0];
  assign out_resp2 = resp_q[1];
  assign out_resp3 = resp_q[2];
  assign out_resp4 = resp_q[3];
  assign out_data1 = data_q[0];
  assign out_data2 = data_q[1];
  assign out_data3 = data_q[2];
  assign out_data4 = data_q[3];

endmodule

// File: tb/tb_calc1_top.sv
// Directed bench for calc1_top: hand-computed vectors, sampled on the falling edge.
module tb_calc1_top;
  import calc1_pkg::*;

  logic        c_clk = 1'b0;
  logic        reset;
  logic [0:3]  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
  logic [0:31] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
  logic [0:1]  out_resp1, out_resp2, out_resp3, out_resp4;
  logic [0:31] out_data1, out_data2, out_data3, out_data4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 c_clk = ~c_clk;

  calc1_top dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (req1_cmd_in),
    .req1_data_in (req1_data_in),
    .req2_cmd_in  (req2_cmd_in),
    .req2_data_in (req2_data_in),
    .req3_cmd_in  (req3_cmd_in),
    .req3_data_in (req3_data_in),
    .req4_cmd_in  (req4_cmd_in),
    .req4_data_in (req4_data_in),
    .out_resp1    (out_resp1),
    .out_data1    (out_data1),
    .out_resp2    (out_resp2),
    .out_data2    (out_data2),
    .out_resp3    (out_resp3),
    .out_data3    (out_data3),
    .out_resp4    (out_resp4),
    .out_data4    (out_data4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge c_clk);
  endtask

  task automatic drive(input int p, input logic [3:0] c, input logic [31:0] d);
    case (p)
      1: begin req1_cmd_in = c; req1_data_in = d; end
      2: begin req2_cmd_in = c; req2_data_in = d; end
      3: begin req3_cmd_in = c; req3_data_in = d; end
      default: begin req4_cmd_in = c; req4_data_in = d; end
    endcase
  endtask

  function automatic logic [31:0] get_resp(input int p);
    case (p)
      1: return {30'b0, out_resp1};
      2: return {30'b0, out_resp2};
      3: return {30'b0, out_resp3};
      default: return {30'b0, out_resp4};
    endcase
  endfunction

  function automatic logic [31:0] get_data(input int p);
    case (p)
      1: return out_data1;
      2: return out_data2;
      3: return out_data3;
      default: return out_data4;
    endcase
  endfunction

  task automatic chk_port(input string tag, input int p, input logic [31:0] er, input logic [31:0] ed);
    chk($sformatf("%s_p%0d_resp", tag, p), get_resp(p), er);
    chk($sformatf("%s_p%0d_data", tag, p), get_data(p), ed);
  endtask

  // Single-port request; caller is on a falling edge in the cmd cycle.
  task automatic run_one(input string tag, input int p, input logic [3:0] c,
                         input logic [31:0] op1, input logic [31:0] op2,
                         input logic [31:0] er, input logic [31:0] ed);
    drive(p, c, op1);
    tick();
    drive(p, 4'd0, op2);
    tick();
    drive(p, 4'd0, 32'd0);
    chk({tag, "_early"}, get_resp(p), 32'd0);
    tick();
    chk_port(tag, p, er, ed);
    tick();
    chk({tag, "_once"}, get_resp(p), 32'd0);
  endtask

  // Drive all four ports at once and expect results in port order.
  task automatic run_all(input string tag, input logic [3:0] c[4],
                         input logic [31:0] op1[4], input logic [31:0] op2[4],
                         input logic [31:0] ed[4]);
    for (int p = 1; p <= 4; p++) drive(p, c[p-1], op1[p-1]);
    tick();
    for (int p = 1; p <= 4; p++) drive(p, 4'd0, op2[p-1]);
    tick();
    for (int p = 1; p <= 4; p++) drive(p, 4'd0, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      for (int p = 1; p <= 4; p++)
        chk_port($sformatf("%s_c%0d", tag, k), p, (p == k) ? 32'd1 : 32'd0, (p == k) ? ed[p-1] : 32'd0);
    end
    tick();
    for (int p = 1; p <= 4; p++) chk($sformatf("%s_done_p%0d", tag, p), get_resp(p), 32'd0);
  endtask

  initial begin
    logic [3:0]  c4[4];
    logic [31:0] a4[4], b4[4], e4[4];
    int          seen;

    for (int p = 1; p <= 4; p++) drive(p, 4'd0, 32'd0);
    reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    tick();
    for (int p = 1; p <= 4; p++) chk_port("reset", p, 32'd0, 32'd0);
    reset = 1'b1;
    tick();

    run_one("add_5_7",   1, CMD_ADD, 32'h5,        32'h7,        32'd1, 32'hC);
    run_one("add_ovf",   2, CMD_ADD, 32'hFFFFFFFF, 32'h1,        32'd2, 32'h0);
    run_one("sub_3_5",   3, CMD_SUB, 32'h3,        32'h5,        32'd2, 32'h0);
    run_one("sub_eq",    3, CMD_SUB, 32'h5,        32'h5,        32'd1, 32'h0);
    run_one("sub_10_3",  2, CMD_SUB, 32'hA,        32'h3,        32'd1, 32'h7);
    run_one("shl_21",    4, CMD_SHL, 32'h1,        32'h21,       32'd1, 32'h2);
    run_one("shr_31",    4, CMD_SHR, 32'h80000000, 32'h1F,       32'd1, 32'h1);
    run_one("inv_7",     2, 4'd7,    32'h12345678, 32'h1,        32'd3, 32'h0);

    c4 = '{CMD_ADD, CMD_ADD, CMD_ADD, CMD_ADD};
    a4 = '{32'd1, 32'd1, 32'd1, 32'd1};
    b4 = '{32'd1, 32'd1, 32'd1, 32'd1};
    e4 = '{32'd2, 32'd2, 32'd2, 32'd2};
    run_all("all_add", c4, a4, b4, e4);

    c4 = '{CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR};
    a4 = '{32'd1, 32'd9, 32'd3, 32'h100};
    b4 = '{32'd2, 32'd4, 32'd2, 32'd4};
    e4 = '{32'd3, 32'd5, 32'd12, 32'h10};
    run_all("bind", c4, a4, b4, e4);

    // Invalid command with a second command offered while it is outstanding.
    drive(1, 4'hF, 32'h1234);
    tick();
    drive(1, CMD_ADD, 32'h5678);
    tick();
    drive(1, CMD_ADD, 32'h1);
    tick();
    drive(1, 4'd0, 32'd0);
    chk_port("inv_f", 1, 32'd3, 32'd0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_resp1 != 2'd0) seen++;
    end
    chk("inv_f_single", seen, 32'd0);

    // Reset while port 1 is in its operand2 cycle and port 2 is responding.
    drive(2, CMD_ADD, 32'd2);
    tick();
    drive(2, 4'd0, 32'd3);
    tick();
    drive(2, 4'd0, 32'd0);
    drive(1, CMD_ADD, 32'd10);
    tick();
    drive(1, 4'd0, 32'd20);
    chk_port("pre_rst", 2, 32'd1, 32'd5);
    #1 reset = 1'b0;
    #1;
    chk_port("rst_now", 2, 32'd0, 32'd0);
    drive(1, 4'd0, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      for (int p = 1; p <= 4; p++) if (get_resp(p) != 32'd0) seen++;
    end
    chk("rst_discard", seen, 32'd0);

    run_one("post_rst", 1, CMD_ADD, 32'h5, 32'h7, 32'd1, 32'hC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
